register_pipe: RTL and testbench

REGISTER_PIPE -- requirements
Module: register_pipe

---
 rtl/register_pipe_pkg.sv | 12 +
 rtl/register_pipe_if.sv | 26 ++
 rtl/register_pipe_stage.sv | 38 +++
 rtl/register_pipe.sv | 91 +++++++++
 tb/tb_register_pipe.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/register_pipe_pkg.sv
// Shared constants and helpers for the register_pipe slice.
package register_pipe_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 2;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/register_pipe_if.sv
// Stream interface of register_pipe: upstream word port, downstream word port, occupancy.
interface register_pipe_if import register_pipe_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
);
    // A word moves across a port only on a rising edge where its valid and ready
    // are both high; valid never waits on ready, and a held word stays unchanged.
    logic                          in_valid;
    logic [WIDTH-1:0]              in0;
    logic                          in_ready;
    logic                          out_valid;
    logic [WIDTH-1:0]              out;
    logic                          out_ready;
    logic [count_width(DEPTH)-1:0] count;

    modport master (
        output in_valid, in0, out_ready,
        input  in_ready, out_valid, out, count
    );

    modport slave (
        input  in_valid, in0, out_ready,
        output in_ready, out_valid, out, count
    );

endinterface

// File: rtl/register_pipe_stage.sv
// One pipeline stage: valid bit and data register with bubble-collapsing load/hold.
// Optional clear input under REGISTER_PIPE_FLUSH_EN.
module register_pipe_stage import register_pipe_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
`ifdef REGISTER_PIPE_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             down_ready,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Free to load when empty or when the held word leaves on this same edge.
    assign ready = !valid || down_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end
`ifdef REGISTER_PIPE_FLUSH_EN
        else if (flush) begin
            valid <= 1'b0;
        end
`endif
        else if (ready) begin
            valid <= up_valid;
            if (up_valid) data <= up_data;
        end
    end

endmodule

// File: rtl/register_pipe.sv
// DEPTH-stage valid/ready register pipe with occupancy count.
// Define REGISTER_PIPE_FLUSH_EN to add the synchronous flush input.
module register_pipe import register_pipe_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic clock,
    input  logic reset,
`ifdef REGISTER_PIPE_FLUSH_EN
    input  logic flush,
`endif
    register_pipe_if.slave bus
);

    localparam int CW = count_width(DEPTH);

    logic             stage_valid [DEPTH];
    logic [WIDTH-1:0] stage_data  [DEPTH];
    logic             stage_ready [DEPTH];
    logic             hold_off;
    logic             in_fire;
    logic             out_fire;
    logic [CW-1:0]    count_q;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;
        logic             down_ready;

        if (k == 0) begin : g_head
            assign up_valid = bus.in_valid;
            assign up_data  = bus.in0;
        end else begin : g_body
            assign up_valid = stage_valid[k-1];
            assign up_data  = stage_data[k-1];
        end

        if (k == DEPTH - 1) begin : g_tail
            assign down_ready = bus.out_ready;
        end else begin : g_inner
            assign down_ready = stage_ready[k+1];
        end

        register_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clock      (clock),
            .reset      (reset),
`ifdef REGISTER_PIPE_FLUSH_EN
            .flush      (flush),
`endif
            .up_valid   (up_valid),
            .up_data    (up_data),
            .down_ready (down_ready),
            .ready      (stage_ready[k]),
            .valid      (stage_valid[k]),
            .data       (stage_data[k])
        );
    end

    // No word is accepted on a cycle whose edge will clear the pipe anyway.
`ifdef REGISTER_PIPE_FLUSH_EN
    assign hold_off = reset || flush;
`else
    assign hold_off = reset;
`endif

    assign bus.in_ready  = stage_ready[0] && !hold_off;
    assign bus.out_valid = stage_valid[DEPTH-1];
    assign bus.out       = stage_data[DEPTH-1];
    assign bus.count     = count_q;

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end
`ifdef REGISTER_PIPE_FLUSH_EN
        else if (flush) begin
            count_q <= '0;
        end
`endif
        else if (in_fire && !out_fire) begin
            count_q <= count_q + CW'(1);
        end
        else if (out_fire && !in_fire) begin
            count_q <= count_q - CW'(1);
        end
    end

endmodule

// File: tb/tb_register_pipe.sv
// Bench for register_pipe: three instances (DEPTH 2, 3, 4) against a queue-based
// reference model; flush scenario only when REGISTER_PIPE_FLUSH_EN is defined.
module tb_register_pipe;

    localparam int W    = 8;
    localparam int NDUT = 3;

    logic         clock;
    logic         reset;
    logic         iv   [NDUT];
    logic [W-1:0] id   [NDUT];
    logic         ordy [NDUT];
    logic         ir   [NDUT];
    logic         ov   [NDUT];
    logic [W-1:0] od   [NDUT];
    logic [2:0]   cnt  [NDUT];
`ifdef REGISTER_PIPE_FLUSH_EN
    logic         fl   [NDUT];
`endif

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int D = g + 2;
        register_pipe_if #(.WIDTH(W), .DEPTH(D)) bus ();

        assign bus.in_valid  = iv[g];
        assign bus.in0       = id[g];
        assign bus.out_ready = ordy[g];
        assign ir[g]         = bus.in_ready;
        assign ov[g]         = bus.out_valid;
        assign od[g]         = bus.out;
        assign cnt[g]        = 3'(bus.count);

        register_pipe #(.WIDTH(W), .DEPTH(D)) dut (
            .clock (clock),
            .reset (reset),
`ifdef REGISTER_PIPE_FLUSH_EN
            .flush (fl[g]),
`endif
            .bus   (bus)
        );
    end

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model state ----------------
    int checks = 0;
    int errors = 0;
    int idx;
    int depth;
    int cyc;
    logic [W-1:0] exp_q [$];
    int           acc_q [$];
    logic [W-1:0] sent_q [$];
    logic [W-1:0] seen_q [$];
    int           last_leave;
    logic [W-1:0] last_out;
    bit           out_known;
    int           max_cnt;
    bit           obs_valid;
    bit           obs_ready;
    logic [W-1:0] obs_data;
    int           obs_cnt;
    int           obs_cyc;
    bit           accepted;

    // ---------------- driver tasks ----------------
    task automatic select_dut(input int d);
        idx   = d - 2;
        depth = d;
        for (int g = 0; g < NDUT; g++) begin
            iv[g]   = 1'b0;
            id[g]   = '0;
            ordy[g] = 1'b0;
`ifdef REGISTER_PIPE_FLUSH_EN
            fl[g]   = 1'b0;
`endif
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        acc_q.delete();
        sent_q.delete();
        seen_q.delete();
        cyc        = 0;
        last_leave = -100;
        last_out   = '0;
        out_known  = 1'b1;
        max_cnt    = 0;
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model.
    task automatic cycle(input bit v, input logic [W-1:0] data, input bit o,
                         input bit r, input bit f);
        bit exp_valid;
        bit exp_ready;
        bit out_fire;
        bit in_fire;
        int avail;
        iv[idx]   = v;
        id[idx]   = data;
        ordy[idx] = o;
        reset     = r;
`ifdef REGISTER_PIPE_FLUSH_EN
        fl[idx]   = f;
`endif
        @(negedge clock);
        exp_valid = 1'b0;
        if (exp_q.size() > 0) begin
            // A word shows up DEPTH cycles after acceptance, but never before
            // the cycle after its predecessor left.
            avail = acc_q[0] + depth;
            if (last_leave + 1 > avail) avail = last_leave + 1;
            exp_valid = (cyc >= avail);
        end
        exp_ready = !r && !f && ((exp_q.size() < depth) || o);

        checks++;
        if (ov[idx] !== exp_valid) begin
            errors++;
            $display("FAIL out_valid depth=%0d cyc=%0d got=%0b exp=%0b", depth, cyc, ov[idx], exp_valid);
        end
        if (exp_valid) begin
            checks++;
            if (od[idx] !== exp_q[0]) begin
                errors++;
                $display("FAIL out_data depth=%0d cyc=%0d got=%02h exp=%02h", depth, cyc, od[idx], exp_q[0]);
            end
        end else if (out_known) begin
            checks++;
            if (od[idx] !== last_out) begin
                errors++;
                $display("FAIL out_hold depth=%0d cyc=%0d got=%02h exp=%02h", depth, cyc, od[idx], last_out);
            end
        end
        checks++;
        if (cnt[idx] !== 3'(exp_q.size())) begin
            errors++;
            $display("FAIL count depth=%0d cyc=%0d got=%0d exp=%0d", depth, cyc, cnt[idx], exp_q.size());
        end
        checks++;
        if (ir[idx] !== exp_ready) begin
            errors++;
            $display("FAIL in_ready depth=%0d cyc=%0d got=%0b exp=%0b", depth, cyc, ir[idx], exp_ready);
        end

        obs_valid = ov[idx];
        obs_ready = ir[idx];
        obs_data  = od[idx];
        obs_cnt   = int'(cnt[idx]);
        obs_cyc   = cyc;
        if (obs_cnt > max_cnt) max_cnt = obs_cnt;
        if (ov[idx] && o && !r) seen_q.push_back(od[idx]);

        out_fire = exp_valid && o;
        in_fire  = v && exp_ready;
        accepted = in_fire;
        @(posedge clock);
        #1;
        if (r) begin
            exp_q.delete();
            acc_q.delete();
            last_out  = '0;
            out_known = 1'b1;
        end else if (f) begin
            exp_q.delete();
            acc_q.delete();
            out_known = 1'b0;
        end else begin
            if (out_fire) begin
                last_out   = exp_q.pop_front();
                void'(acc_q.pop_front());
                last_leave = cyc;
                out_known  = 1'b1;
            end
            if (in_fire) begin
                exp_q.push_back(data);
                acc_q.push_back(cyc);
                sent_q.push_back(data);
            end
        end
        cyc++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clock);
        for (int g = 0; g < NDUT; g++) begin
            checks++;
            if (ov[g] !== 1'b0) begin errors++; $display("FAIL reset_out_valid dut=%0d got=%0b exp=0", g, ov[g]); end
            checks++;
            if (od[g] !== '0) begin errors++; $display("FAIL reset_out dut=%0d got=%02h exp=00", g, od[g]); end
            checks++;
            if (cnt[g] !== 3'd0) begin errors++; $display("FAIL reset_count dut=%0d got=%0d exp=0", g, cnt[g]); end
            checks++;
            if (ir[g] !== 1'b1) begin errors++; $display("FAIL reset_in_ready dut=%0d got=%0b exp=1", g, ir[g]); end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_streaming();
        int first_out;
        int n_acc;
        int c0;
        select_dut(3);
        first_out = -1;
        n_acc     = 0;
        c0        = cyc;
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
            if (accepted) n_acc++;
            if (obs_valid && first_out < 0) first_out = obs_cyc;
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (n_acc != 10) begin errors++; $display("FAIL stream_accepts got=%0d exp=10", n_acc); end
        checks++;
        if (first_out - c0 != 3) begin errors++; $display("FAIL stream_latency got=%0d exp=3", first_out - c0); end
        checks++;
        if (max_cnt != 3) begin errors++; $display("FAIL stream_peak_count got=%0d exp=3", max_cnt); end
        checks++;
        if (seen_q.size() != 10) begin
            errors++;
            $display("FAIL stream_out_len got=%0d exp=10", seen_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (seen_q[i] !== 8'(i + 1)) begin
                    errors++;
                    $display("FAIL stream_order pos=%0d got=%02h exp=%02h", i, seen_q[i], 8'(i + 1));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] want [3];
        bit done;
        select_dut(2);
        want[0] = 8'hA5;
        want[1] = 8'h5A;
        want[2] = 8'h33;
        cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        checks++;
        if (!accepted) begin errors++; $display("FAIL bp_accept_a5 got=0 exp=1"); end
        cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        checks++;
        if (!accepted) begin errors++; $display("FAIL bp_accept_5a got=0 exp=1"); end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs_ready || obs_cnt != 2) begin
                errors++;
                $display("FAIL bp_stall in_ready=%0b count=%0d exp in_ready=0 count=2", obs_ready, obs_cnt);
            end
        end
        done = 1'b0;
        for (int i = 0; i < 6 && !done; i++) begin
            cycle(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
            done = accepted;
        end
        checks++;
        if (!done) begin errors++; $display("FAIL bp_accept_33 got=0 exp=1"); end
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (seen_q.size() != 3) begin
            errors++;
            $display("FAIL bp_out_len got=%0d exp=3", seen_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (seen_q[i] !== want[i]) begin
                    errors++;
                    $display("FAIL bp_order pos=%0d got=%02h exp=%02h", i, seen_q[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_full_simultaneous();
        select_dut(2);
        cycle(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h03, 1'b1, 1'b0, 1'b0);
        checks++;
        if (!obs_ready || obs_cnt != 2) begin
            errors++;
            $display("FAIL full_in_ready in_ready=%0b count=%0d exp in_ready=1 count=2", obs_ready, obs_cnt);
        end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_cnt != 2) begin errors++; $display("FAIL full_count_after got=%0d exp=2", obs_cnt); end
    endtask

    task automatic test_reset_mid();
        int c0;
        bit seen;
        select_dut(4);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_cnt != 3) begin errors++; $display("FAIL rmid_fill got=%0d exp=3", obs_cnt); end
        cycle(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_valid || obs_data !== 8'h00 || obs_cnt != 0 || !obs_ready) begin
            errors++;
            $display("FAIL rmid_cleared out_valid=%0b out=%02h count=%0d in_ready=%0b exp 0/00/0/1",
                     obs_valid, obs_data, obs_cnt, obs_ready);
        end
        c0 = cyc;
        cycle(1'b1, 8'h7E, 1'b1, 1'b0, 1'b0);
        checks++;
        if (!accepted) begin errors++; $display("FAIL rmid_accept_7e got=0 exp=1"); end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
            seen = obs_valid;
        end
        checks++;
        if (!seen || obs_cyc - c0 != 4 || obs_data !== 8'h7E) begin
            errors++;
            $display("FAIL rmid_latency seen=%0b lat=%0d out=%02h exp 1/4/7e", seen, obs_cyc - c0, obs_data);
        end
    endtask

    task automatic test_bubble();
        select_dut(3);
        cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_cnt != 2) begin errors++; $display("FAIL bubble_count got=%0d exp=2", obs_cnt); end
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (!obs_valid || obs_data !== 8'h11) begin
            errors++;
            $display("FAIL bubble_first valid=%0b out=%02h exp 1/11", obs_valid, obs_data);
        end
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (!obs_valid || obs_data !== 8'h22) begin
            errors++;
            $display("FAIL bubble_packed valid=%0b out=%02h exp 1/22", obs_valid, obs_data);
        end
    endtask

    task automatic test_random();
        for (int d = 2; d <= 4; d++) begin
            select_dut(d);
            for (int i = 0; i < 300; i++) begin
                cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                      ($urandom_range(0, 3) != 0) ^ (i >= 150 && i < 200), 1'b0, 1'b0);
            end
            for (int i = 0; i < d + 4; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (seen_q.size() != sent_q.size()) begin
                errors++;
                $display("FAIL rand_len depth=%0d got=%0d exp=%0d", d, seen_q.size(), sent_q.size());
            end else begin
                for (int i = 0; i < sent_q.size(); i++) begin
                    checks++;
                    if (seen_q[i] !== sent_q[i]) begin
                        errors++;
                        $display("FAIL rand_order depth=%0d pos=%0d got=%02h exp=%02h", d, i, seen_q[i], sent_q[i]);
                    end
                end
            end
        end
    endtask

`ifdef REGISTER_PIPE_FLUSH_EN
    task automatic test_flush();
        select_dut(3);
        cycle(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_cnt != 3) begin errors++; $display("FAIL flush_fill got=%0d exp=3", obs_cnt); end
        cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs_ready || accepted) begin errors++; $display("FAIL flush_in_ready got=%0b exp=0", obs_ready); end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_cnt != 0 || obs_valid) begin
            errors++;
            $display("FAIL flush_cleared count=%0d out_valid=%0b exp 0/0", obs_cnt, obs_valid);
        end
        cycle(1'b1, 8'h5C, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (seen_q.size() != 1 || seen_q[0] !== 8'h5C) begin
            errors++;
            $display("FAIL flush_after len=%0d first=%02h exp 1/5c", seen_q.size(),
                     (seen_q.size() > 0) ? seen_q[0] : 8'h00);
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b1;
        for (int g = 0; g < NDUT; g++) begin
            iv[g]   = 1'b0;
            id[g]   = '0;
            ordy[g] = 1'b0;
`ifdef REGISTER_PIPE_FLUSH_EN
            fl[g]   = 1'b0;
`endif
        end
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_full_simultaneous();
        test_reset_mid();
        test_bubble();
        test_random();
`ifdef REGISTER_PIPE_FLUSH_EN
        test_flush();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
